seven_seg_scan_decoder: RTL and testbench

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

---
 rtl/seven_seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a 4-digit hex value by watching a multiplexed 7-segment display scan.
// Define SEVSEG_ERR_CNT_EN to add the saturating 8-bit err_cnt output.
module seven_seg_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg_in,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        digit_err,
   output logic [1:0]  err_idx
`ifdef SEVSEG_ERR_CNT_EN
   ,
   output logic [7:0]  err_cnt
`endif
);

   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_IGNORE = 2'd2;

   localparam logic [7:0] CNT_MAX     = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_CAPTURE = 8'(STABLE_CYCLES - 2);

   logic [3:0]  an_s1, an_s2;
   logic [6:0]  seg_s1, seg_s2;
   logic [10:0] samp, samp_prev;
   logic        changed;
   logic [7:0]  cnt;
   logic [1:0]  state;
   logic        one_low;
   logic [1:0]  idx;
   logic [3:0]  nib;
   logic        nib_ok;
   logic        capture;
   logic [3:0]  captured;
   logic [3:0]  cap_next;
   logic [15:0] slots;
   logic [15:0] frame;

   // The blanked display (all enables high, no segments) is the reset view of the pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_s1  <= 4'hF;
         an_s2  <= 4'hF;
         seg_s1 <= 7'h00;
         seg_s2 <= 7'h00;
      end else begin
         an_s1  <= an;
         an_s2  <= an_s1;
         seg_s1 <= seg_in;
         seg_s2 <= seg_s1;
      end
   end

   assign samp    = {an_s2, seg_s2};
   assign changed = (samp != samp_prev);

   always_comb begin
      one_low = 1'b0;
      idx     = 2'd0;
      case (an_s2)
         4'b1110: begin one_low = 1'b1; idx = 2'd0; end
         4'b1101: begin one_low = 1'b1; idx = 2'd1; end
         4'b1011: begin one_low = 1'b1; idx = 2'd2; end
         4'b0111: begin one_low = 1'b1; idx = 2'd3; end
         default: begin one_low = 1'b0; idx = 2'd0; end
      endcase
   end

   always_comb begin
      nib    = 4'h0;
      nib_ok = 1'b1;
      case (seg_s2)
         7'h3F: nib = 4'h0;
         7'h06: nib = 4'h1;
         7'h5B: nib = 4'h2;
         7'h4F: nib = 4'h3;
         7'h66: nib = 4'h4;
         7'h6D: nib = 4'h5;
         7'h7D: nib = 4'h6;
         7'h07: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h6F: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h7C: nib = 4'hB;
         7'h39: nib = 4'hC;
         7'h5E: nib = 4'hD;
         7'h79: nib = 4'hE;
         7'h71: nib = 4'hF;
         default: nib_ok = 1'b0;
      endcase
   end

   // cnt counts unchanged cycles after the first one, so the current cycle is the (cnt+2)-th.
   assign capture = !changed && (state == ST_SETTLE) && (cnt == CNT_CAPTURE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_prev <= {4'hF, 7'h00};
         cnt       <= 8'd0;
         state     <= ST_IGNORE;
      end else begin
         samp_prev <= samp;
         if (changed) begin
            cnt   <= 8'd0;
            state <= one_low ? ST_SETTLE : ST_IGNORE;
         end else begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + 8'd1;
            end
            if (capture) begin
               state <= ST_HELD;
            end
         end
      end
   end

   assign cap_next = captured | (4'b0001 << idx);

   always_comb begin
      frame                  = slots;
      frame[{idx, 2'b00} +: 4] = nib;
   end

   // Frame assembly: a bad pattern throws away the partial frame but keeps the last good value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value       <= 16'h0000;
         value_valid <= 1'b0;
         digit_err   <= 1'b0;
         err_idx     <= 2'd0;
         captured    <= 4'b0000;
         slots       <= 16'h0000;
      end else begin
         value_valid <= 1'b0;
         digit_err   <= 1'b0;
         if (capture) begin
            if (nib_ok) begin
               slots <= frame;
               if (cap_next == 4'hF) begin
                  value       <= frame;
                  value_valid <= 1'b1;
                  captured    <= 4'b0000;
               end else begin
                  captured <= cap_next;
               end
            end else begin
               digit_err <= 1'b1;
               err_idx   <= idx;
               captured  <= 4'b0000;
            end
         end
      end
   end

`ifdef SEVSEG_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (capture && !nib_ok && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed step table, reset/corner sequences and
// randomized scans checked every cycle against a pin-history reference model.
module tb_seven_seg_scan_decoder;

   localparam int STABLE = 4;
   localparam logic [10:0] RST_S = {4'hF, 7'h00};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg_in = 7'h00;
   logic [15:0] value;
   logic        value_valid;
   logic        digit_err;
   logic [1:0]  err_idx;
`ifdef SEVSEG_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int vcount = 0;
   int ecount = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   seven_seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .an(an),
      .seg_in(seg_in),
      .value(value),
      .value_valid(value_valid),
      .digit_err(digit_err),
      .err_idx(err_idx)
`ifdef SEVSEG_ERR_CNT_EN
      ,
      .err_cnt(err_cnt)
`endif
   );

   logic [6:0] hexpat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles);
      an = a;
      seg_in = s;
      repeat (cycles) @(negedge clk);
      #1;
   endtask

   // Reference model: a digit is captured when the pin sample seen by the logic (two edges late)
   // has been identical for exactly STABLE cycles and shows exactly one enabled digit.
   logic [10:0] hist [$];
   logic [15:0] m_value, m_slots;
   logic [3:0]  m_cap;
   logic        m_valid, m_err;
   logic [1:0]  m_idx;
   int          m_errcnt;
   logic [10:0] cur;
   int          run, pos, nibv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         hist.push_back(RST_S);
         hist.push_back(RST_S);
         m_value = 16'h0; m_slots = 16'h0; m_cap = 4'h0;
         m_valid = 1'b0; m_err = 1'b0; m_idx = 2'd0; m_errcnt = 0;
      end else begin
         hist.push_back({an, seg_in});
         if (hist.size() > 64) hist.delete(0);
         m_valid = 1'b0;
         m_err = 1'b0;
         cur = hist[hist.size() - 3];
         run = 0;
         for (int j = hist.size() - 3; j >= 0 && run <= STABLE; j--) begin
            if (hist[j] == cur) run++;
            else break;
         end
         if (run == STABLE && $countones(~cur[10:7]) == 1) begin
            pos = 0;
            for (int b = 0; b < 4; b++) if (!cur[7 + b]) pos = b;
            nibv = -1;
            for (int d = 0; d < 16; d++) if (hexpat[d] == cur[6:0]) nibv = d;
            if (nibv >= 0) begin
               m_slots[pos*4 +: 4] = 4'(nibv);
               m_cap[pos] = 1'b1;
               if (m_cap == 4'hF) begin
                  m_value = m_slots;
                  m_valid = 1'b1;
                  m_cap = 4'h0;
               end
            end else begin
               m_err = 1'b1;
               m_idx = 2'(pos);
               m_cap = 4'h0;
               if (m_errcnt < 255) m_errcnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (value_valid) vcount++;
      if (digit_err) ecount++;
      if (check_en) begin
         checkOutput("cyc_value", 32'(value), 32'(m_value));
         checkOutput("cyc_valid", 32'(value_valid), 32'(m_valid));
         checkOutput("cyc_err", 32'(digit_err), 32'(m_err));
         checkOutput("cyc_err_idx", 32'(err_idx), 32'(m_idx));
         checkOutput("cyc_valid_err_excl", 32'(value_valid & digit_err), 32'd0);
`ifdef SEVSEG_ERR_CNT_EN
         checkOutput("cyc_err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
      end
   end

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          cycles;
      logic [15:0] exp_value;
      int          exp_valid;
      int          exp_err;
      logic [1:0]  exp_idx;
   } step_t;

   step_t steps [19];
   int v0, e0;
   logic [3:0] r_an;
   logic [6:0] r_seg;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Basic scan, short digit, bad pattern, fresh scan, blanking between digits
      steps[0]  = '{4'hE, 7'h06, 10, 16'h0000, 0, 0, 2'd0};
      steps[1]  = '{4'hD, 7'h5B, 10, 16'h0000, 0, 0, 2'd0};
      steps[2]  = '{4'hB, 7'h4F, 10, 16'h0000, 0, 0, 2'd0};
      steps[3]  = '{4'h7, 7'h66, 10, 16'h4321, 1, 0, 2'd0};
      steps[4]  = '{4'hE, 7'h3F,  3, 16'h4321, 0, 0, 2'd0};
      steps[5]  = '{4'hD, 7'h7D, 10, 16'h4321, 0, 0, 2'd0};
      steps[6]  = '{4'hB, 7'h07, 10, 16'h4321, 0, 0, 2'd0};
      steps[7]  = '{4'h7, 7'h7F, 10, 16'h4321, 0, 0, 2'd0};
      steps[8]  = '{4'hB, 7'h00, 10, 16'h4321, 0, 1, 2'd2};
      steps[9]  = '{4'hE, 7'h77, 10, 16'h4321, 0, 0, 2'd0};
      steps[10] = '{4'hD, 7'h7C, 10, 16'h4321, 0, 0, 2'd0};
      steps[11] = '{4'hB, 7'h39, 10, 16'h4321, 0, 0, 2'd0};
      steps[12] = '{4'h7, 7'h5E, 10, 16'hDCBA, 1, 0, 2'd0};
      steps[13] = '{4'hE, 7'h06, 10, 16'hDCBA, 0, 0, 2'd0};
      steps[14] = '{4'hF, 7'h00, 20, 16'hDCBA, 0, 0, 2'd0};
      steps[15] = '{4'hD, 7'h5B, 10, 16'hDCBA, 0, 0, 2'd0};
      steps[16] = '{4'hC, 7'h5B, 20, 16'hDCBA, 0, 0, 2'd0};
      steps[17] = '{4'hB, 7'h4F, 10, 16'hDCBA, 0, 0, 2'd0};
      steps[18] = '{4'h7, 7'h66, 10, 16'h4321, 1, 0, 2'd0};

      #2;
      rst_n = 1'b0;
      check_en = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_value", 32'(value), 32'h0);
      checkOutput("reset_valid", 32'(value_valid), 32'h0);
      checkOutput("reset_err", 32'(digit_err), 32'h0);
      checkOutput("reset_err_idx", 32'(err_idx), 32'h0);
      rst_n = 1'b1;
      applyStimulus(4'hF, 7'h00, 4);

      for (int i = 0; i < 19; i++) begin
         v0 = vcount;
         e0 = ecount;
         applyStimulus(steps[i].an, steps[i].seg, steps[i].cycles);
         checkOutput($sformatf("step%0d_value", i), 32'(value), 32'(steps[i].exp_value));
         checkOutput($sformatf("step%0d_valid_pulses", i), 32'(vcount - v0), 32'(steps[i].exp_valid));
         checkOutput($sformatf("step%0d_err_pulses", i), 32'(ecount - e0), 32'(steps[i].exp_err));
         if (steps[i].exp_err > 0)
            checkOutput($sformatf("step%0d_err_idx", i), 32'(err_idx), 32'(steps[i].exp_idx));
      end

      // Reset in the middle of a frame, after two digits are held
      applyStimulus(4'hE, 7'h06, 10);
      applyStimulus(4'hD, 7'h5B, 10);
      #2;
      rst_n = 1'b0;
      an = 4'hF;
      seg_in = 7'h00;
      #1;
      checkOutput("midreset_value", 32'(value), 32'h0);
      checkOutput("midreset_valid", 32'(value_valid), 32'h0);
      checkOutput("midreset_err", 32'(digit_err), 32'h0);
      checkOutput("midreset_err_idx", 32'(err_idx), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      v0 = vcount;
      applyStimulus(4'hB, 7'h4F, 10);
      applyStimulus(4'h7, 7'h66, 10);
      applyStimulus(4'hE, 7'h06, 10);
      checkOutput("postreset_no_frame", 32'(vcount - v0), 32'd0);
      checkOutput("postreset_value_zero", 32'(value), 32'h0);
      applyStimulus(4'hD, 7'h5B, 10);
      checkOutput("postreset_frame", 32'(vcount - v0), 32'd1);
      checkOutput("postreset_value", 32'(value), 32'h4321);

      // Randomized scans with blanking, junk patterns and occasional resets
      for (int r = 0; r < 400; r++) begin
         case ($urandom_range(0, 9))
            0: r_an = 4'hF;
            1: r_an = 4'($urandom);
            default: r_an = ~(4'b0001 << $urandom_range(0, 3));
         endcase
         if ($urandom_range(0, 4) == 0) r_seg = 7'($urandom);
         else r_seg = hexpat[$urandom_range(0, 15)];
         applyStimulus(r_an, r_seg, $urandom_range(1, 12));
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            rst_n = 1'b1;
         end
      end

`ifdef SEVSEG_ERR_CNT_EN
      for (int k = 0; k < 150; k++) begin
         applyStimulus(4'hE, 7'h00, 6);
         applyStimulus(4'hD, 7'h00, 6);
      end
      checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);
      applyStimulus(4'hB, 7'h00, 6);
      applyStimulus(4'h7, 7'h00, 6);
      checkOutput("err_cnt_held", 32'(err_cnt), 32'd255);
`endif

      applyStimulus(4'hF, 7'h00, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
